// File: rtl/bram_cfg_pkg.sv
// Shared constants and helpers for the configurable byte-write true dual-port RAM.
package bram_cfg_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Address width for a given depth; never narrower than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/bram_cfg_rdpath.sv
// Per-port read path: write-mode mux, stage-1 data/valid and optional output register.
module bram_cfg_rdpath
  import bram_cfg_pkg::*;
#(
  parameter int NB_COL    = 4,
  parameter int COL_WIDTH = 8,
  parameter int MODE      = WM_WRITE_FIRST,
  parameter int OUT_REG   = 1,
  localparam int DW       = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NB_COL-1:0] we,
  input  logic [DW-1:0]     din,
  input  logic [DW-1:0]     old_word,
  input  logic              regce,
  output logic [DW-1:0]     dout,
  output logic              dout_vld
);

  // dout_vld qualifies dout for exactly one cycle; there is no backpressure,
  // so a consumer must take the word in the cycle dout_vld is high.
  logic [DW-1:0] wf_word;
  logic [DW-1:0] data1;
  logic          vld1;
  logic          load1;

  always_comb begin
    wf_word = old_word;
    for (int i = 0; i < NB_COL; i++) begin
      if (we[i]) wf_word[i*COL_WIDTH +: COL_WIDTH] = din[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  // NO_CHANGE keeps stage 1 frozen during writes; other modes load on every enable.
  assign load1 = en & ((MODE != WM_NO_CHANGE) | (we == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data1 <= '0;
      vld1  <= 1'b0;
    end else begin
      vld1 <= load1;
      if (load1) data1 <= (MODE == WM_WRITE_FIRST) ? wf_word : old_word;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout     <= '0;
        dout_vld <= 1'b0;
      end else if (regce) begin
        dout     <= data1;
        dout_vld <= vld1;
      end else begin
        dout_vld <= 1'b0;
      end
    end
  end else begin : g_noreg
    logic unused_regce;
    assign unused_regce = regce;
    assign dout         = data1;
    assign dout_vld     = vld1;
  end

endmodule

// File: rtl/bytewrite_tdp_ram_cfg.sv
// Single-clock true dual-port RAM with byte enables, per-port write mode,
// same-address write collision resolution and a registered collision flag.
module bytewrite_tdp_ram_cfg
  import bram_cfg_pkg::*;
#(
  parameter int NB_COL       = 4,
  parameter int COL_WIDTH    = 8,
  parameter int RAM_DEPTH    = 1024,
  parameter int WRITE_MODE_A = WM_WRITE_FIRST,
  parameter int WRITE_MODE_B = WM_WRITE_FIRST,
  parameter int OUT_REG      = 1,
  parameter int PRIORITY_A   = 1,
  localparam int AW          = clog2(RAM_DEPTH),
  localparam int DW          = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NB_COL-1:0] wea,
  input  logic [AW-1:0]     addra,
  input  logic [DW-1:0]     dina,
  input  logic              regcea,
  output logic [DW-1:0]     douta,
  output logic              douta_vld,
  input  logic              enb,
  input  logic [NB_COL-1:0] web,
  input  logic [AW-1:0]     addrb,
  input  logic [DW-1:0]     dinb,
  input  logic              regceb,
  output logic [DW-1:0]     doutb,
  output logic              doutb_vld,
  output logic              collision
);

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(RAM_DEPTH);

  logic [DW-1:0]     mem [RAM_DEPTH];
  logic              en_a, en_b, in_a, in_b, act_a, act_b, same;
  logic [NB_COL-1:0] we_a, we_b, wr_a, wr_b;
  logic [DW-1:0]     old_a, old_b, word_a, word_b;

  // Enables are gated by reset; out-of-range addresses make a port inert.
  assign en_a  = ena & rst_n;
  assign en_b  = enb & rst_n;
  assign in_a  = {1'b0, addra} < DEPTH_LIM;
  assign in_b  = {1'b0, addrb} < DEPTH_LIM;
  assign act_a = en_a & in_a;
  assign act_b = en_b & in_b;
  assign we_a  = in_a ? wea : '0;
  assign we_b  = in_b ? web : '0;
  assign wr_a  = wea & {NB_COL{act_a}};
  assign wr_b  = web & {NB_COL{act_b}};
  assign same  = act_a & act_b & (addra == addrb);
  assign old_a = in_a ? mem[addra] : '0;
  assign old_b = in_b ? mem[addrb] : '0;

  // On a same-address write both ports build the identical merged word, with the
  // priority port owning overlapping bytes, so either write lands the same value.
  always_comb begin
    word_a = old_a;
    word_b = old_b;
    for (int i = 0; i < NB_COL; i++) begin
      if (wr_a[i]) word_a[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
      if (same && wr_b[i] && !(wr_a[i] && (PRIORITY_A != 0)))
        word_a[i*COL_WIDTH +: COL_WIDTH] = dinb[i*COL_WIDTH +: COL_WIDTH];
      if (wr_b[i]) word_b[i*COL_WIDTH +: COL_WIDTH] = dinb[i*COL_WIDTH +: COL_WIDTH];
      if (same && wr_a[i] && !(wr_b[i] && (PRIORITY_A == 0)))
        word_b[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a != '0) mem[addra] <= word_a;
    if (wr_b != '0) mem[addrb] <= word_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) collision <= 1'b0;
    else        collision <= same & ((wr_a & wr_b) != '0);
  end

  bram_cfg_rdpath #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .MODE(WRITE_MODE_A), .OUT_REG(OUT_REG)
  ) u_rdpath_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .we(we_a), .din(dina), .old_word(old_a),
    .regce(regcea), .dout(douta), .dout_vld(douta_vld)
  );

  bram_cfg_rdpath #(
    .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .MODE(WRITE_MODE_B), .OUT_REG(OUT_REG)
  ) u_rdpath_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .we(we_b), .din(dinb), .old_word(old_b),
    .regce(regceb), .dout(doutb), .dout_vld(doutb_vld)
  );

endmodule

// File: doc/bytewrite_tdp_ram_cfg.md
Name: bytewrite_tdp_ram_cfg

Overview:
- Single-clock true dual-port RAM with byte-write enables.
- Write mode selectable per port: WRITE_FIRST, READ_FIRST or NO_CHANGE.
- Optional output register, per-port read-valid tracking, defined same-address collision priority and a collision flag.
- Next-generation configurable BRAM primitive wrapper for shared buffers, register files and packet stores.

Parameters:
- NB_COL, 4, number of byte columns
- COL_WIDTH, 8, column width in bits (8 or 9)
- RAM_DEPTH, 1024, number of entries; need not be a power of 2
- WRITE_MODE_A, 0, port A mode: 0=WRITE_FIRST, 1=READ_FIRST, 2=NO_CHANGE
- WRITE_MODE_B, 0, port B mode, same encoding
- OUT_REG, 1, 0 = one-cycle read latency; 1 = extra output register stage
- PRIORITY_A, 1, 1 = port A wins a same-address same-byte write collision; 0 = port B wins
- Derived localparams: AW = clog2(RAM_DEPTH), DW = NB_COL*COL_WIDTH

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  port A enable
- wea  in  NB_COL  port A byte write enables
- addra  in  AW  port A address
- dina  in  DW  port A write data
- regcea  in  1  port A output register enable; ignored when OUT_REG=0
- douta  out  DW  port A read data
- douta_vld  out  1  port A read data valid
- enb, web, addrb, dinb, regceb, doutb, doutb_vld: port B equivalents, same widths
- collision  out  1  registered pulse flagging a same-address overlapping-byte write

Behaviour:
- Reset (rst_n low, async): stage-1 data, douta/doutb, *_vld and collision all go to 0. Array contents are not reset.
- While rst_n is low, ena and enb are internally gated, so no writes occur.
- Address range: addr >= RAM_DEPTH makes the port inert for that cycle. Writes are ignored, stage-1 data loads 0, *_vld still asserts, no collision is raised.
- Per-byte write: byte i of mem[addr] is updated when en & we[i].
- Stage-1 data per mode:
  - WRITE_FIRST: written bytes take din; unwritten bytes take the old memory contents.
  - READ_FIRST: all bytes take the old contents.
  - NO_CHANGE: stage-1 data updates only when en & we==0; it holds when any we bit is set.
- Stage-1 valid: vld1 <= en & (mode!=NO_CHANGE | we==0).
- Latency, OUT_REG=0: dout = stage-1 data, dout_vld = vld1. Data appears one cycle after the enable.
- Latency, OUT_REG=1: if regce, dout <= stage-1 data and dout_vld <= vld1; else dout holds and dout_vld <= 0. Data appears two cycles after the enable.
- Cross-port read-during-write (one port writes X, the other reads X in the same cycle): the reader sees the OLD contents. No flag is raised.
- Write-write collision: ena & enb, addra==addrb (in range), and (wea & web) != 0.
  - Overlapping bytes take the data of the priority port.
  - Non-overlapping bytes from both ports are merged.
  - collision = 1 for exactly one cycle after the event.
  - Each port's own WRITE_FIRST readback shows its own din, not the merged word.
- Writes to the same address with disjoint we are merged and set no collision.
- Back-to-back accesses every cycle are fully pipelined; no stalls.

Decomposition:
- Package bram_cfg_pkg:
  - mode constants WM_WRITE_FIRST=0, WM_READ_FIRST=1, WM_NO_CHANGE=2
  - clog2 function
- Sub-module bram_cfg_rdpath, instantiated once per port:
  - mode mux, vld1, optional output register and valid
  - takes the old word, din and we; produces dout and dout_vld
- Array, collision resolution and collision flag stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with ena=enb=1 and we=all ones -> douta, doutb, vld and collision are 0. After release, reading the written address shows the pre-reset contents unchanged.
- WRITE_FIRST, OUT_REG=1, regcea=1: write addr 5, dina=0xAABBCCDD, wea=1111 -> two cycles later douta=0xAABBCCDD, douta_vld=1.
- READ_FIRST byte write: mem[5]=0xAABBCCDD; A writes wea=0010, dina=0x11223344 -> douta=0xAABBCCDD. A subsequent read of 5 returns 0xAABB33DD.
- Collision, PRIORITY_A=1: A writes 7 with 0x11111111 / 1111 and B writes 7 with 0x22222222 / 0011 -> mem[7]=0x11111111, collision pulses 1 cycle. Repeat with wea=0011, web=1100 -> mem[7]=0x22221111, collision=0.
- Cross-port: mem[9]=0x0; A writes 9 with 0xDEADBEEF while B reads 9 -> doutb=0x0. Next B read -> 0xDEADBEEF.
- NO_CHANGE and range, RAM_DEPTH=1000: write on a NO_CHANGE port leaves dout unchanged and dout_vld=0. Write to addr 1000 is ignored (addr 1000 maps to no entry; mem[0] and mem[999] are unchanged); a read of addr 1000 returns 0 with dout_vld=1.
